// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory arbiter: ownership states and requester IDs.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin picker: a lone eligible requester wins, ties go to ptr.
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic       elig0,
  input  logic       elig1,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (elig0 && elig1) begin
      gnt = (ptr == REQ_LDR) ? 2'b10 : 2'b01;
    end else if (elig0) begin
      gnt = 2'b01;
    end else if (elig1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares a single-port synchronous data memory between the CPU LSU (req0) and
// the loader (req1): round-robin, optional ownership lock, tagged read return.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DATA = 32,
  parameter int ADDR = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic            req0_we,
  input  logic            req0_lock,
  input  logic [ADDR-1:0] req0_addr,
  input  logic [DATA-1:0] req0_wdata,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic            req1_we,
  input  logic            req1_lock,
  input  logic [ADDR-1:0] req1_addr,
  input  logic [DATA-1:0] req1_wdata,
  output logic            req1_ready,
  output logic            rsp0_valid,
  output logic [DATA-1:0] rsp0_rdata,
  output logic            rsp1_valid,
  output logic [DATA-1:0] rsp1_rdata,
  output logic            dm_we,
  output logic [ADDR-1:0] dm_addr,
  output logic [DATA-1:0] dm_wdata,
  input  logic [DATA-1:0] dm_rdata,
  output arb_state_e      dbg_state,
  output logic            dbg_ptr
);

  // Handshake: a beat transfers in any cycle where reqN_valid && reqN_ready.
  // ready is combinational, never high without valid, and at most one side
  // is ready per cycle; the requester holds its beat stable until accepted.

  arb_state_e      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            pend_q, tag_q;
  logic [DATA-1:0] hold0_q, hold1_q;
  logic            elig0, elig1;
  logic [1:0]      gnt;

  assign elig0 = rst_n && req0_valid && (state_q != OWN1);
  assign elig1 = rst_n && req1_valid && (state_q != OWN0);

  dm_arb_rr u_rr (
    .elig0 (elig0),
    .elig1 (elig1),
    .ptr   (ptr_q),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    if (gnt[0]) begin
      dm_we    = req0_we;
      dm_addr  = req0_addr;
      dm_wdata = req0_wdata;
    end else if (gnt[1]) begin
      dm_we    = req1_we;
      dm_addr  = req1_addr;
      dm_wdata = req1_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (gnt[0]) begin
      ptr_d   = REQ_LDR;
      state_d = req0_lock ? OWN0 : IDLE;
    end else if (gnt[1]) begin
      ptr_d   = REQ_CPU;
      state_d = req1_lock ? OWN1 : IDLE;
    end
  end

  // Gating with rst_n drops a pending response in the cycle reset asserts.
  assign rsp0_valid = rst_n && pend_q && (tag_q == REQ_CPU);
  assign rsp1_valid = rst_n && pend_q && (tag_q == REQ_LDR);
  assign rsp0_rdata = rsp0_valid ? dm_rdata : hold0_q;
  assign rsp1_rdata = rsp1_valid ? dm_rdata : hold1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= REQ_CPU;
      pend_q  <= 1'b0;
      tag_q   <= REQ_CPU;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= (|gnt) && !dm_we;
      tag_q   <= gnt[1];
      if (rsp0_valid) hold0_q <= dm_rdata;
      if (rsp1_valid) hold1_q <= dm_rdata;
    end
  end

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory attached.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_we, req0_lock, req0_ready;
  logic [11:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready;
  logic [11:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        dm_we;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  arb_state_e  dbg_state;
  logic        dbg_ptr;

  int checks;
  int errors;

  // clock / reset block
  always #5 clk = ~clk;

  dm_arbiter #(.DATA(32), .ADDR(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // memory model: unwritten words read as a known address pattern
  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hA500_0000 | {20'h0, a};
  endfunction

  logic        mem_clr;
  logic [31:0] mem [0:4095];
  logic [4095:0] written;

  always @(posedge clk) begin
    if (mem_clr) begin
      written  <= '0;
      dm_rdata <= '0;
    end else begin
      dm_rdata <= written[dm_addr] ? mem[dm_addr] : pat(dm_addr);
      if (dm_we) begin
        mem[dm_addr]     <= dm_wdata;
        written[dm_addr] <= 1'b1;
      end
    end
  end

  // driver tasks
  task automatic set0(input logic v, input logic we, input logic lk,
                      input logic [11:0] a, input logic [31:0] d);
    req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic lk,
                      input logic [11:0] a, input logic [31:0] d);
    req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic        w;
  logic [11:0] a0, a1, ga;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    mem_clr = 1'b1;
    set0(1'b1, 1'b1, 1'b0, 12'h3FF, 32'hFFFF_FFFF);
    set1(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);

    // reset: valid held high, nothing may leak out
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_rsp1_rdata", rsp1_rdata, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_ptr", dbg_ptr, 0);
    set0(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_dm_we", dm_we, 0);
      chk("idle_rsp", {rsp0_valid, rsp1_valid}, 0);
    end

    // simultaneous first requests: 0 wins, next contested goes to 1
    set0(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
    set1(1'b1, 1'b0, 1'b0, 12'h021, 32'h0);
    #1;
    chk("sim_rdy0", req0_ready, 1);
    chk("sim_rdy1", req1_ready, 0);
    chk("sim_addr", dm_addr, 12'h020);
    tick();
    set0(1'b1, 1'b0, 1'b0, 12'h022, 32'h0);
    #1;
    chk("sim_rsp0_valid", rsp0_valid, 1);
    chk("sim_rsp0_rdata", rsp0_rdata, pat(12'h020));
    chk("sim2_rdy0", req0_ready, 0);
    chk("sim2_rdy1", req1_ready, 1);
    chk("sim2_addr", dm_addr, 12'h021);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("sim_rsp1_valid", rsp1_valid, 1);
    chk("sim_rsp1_rdata", rsp1_rdata, pat(12'h021));
    chk("sim2_rsp0_valid", rsp0_valid, 0);
    chk("sim3_rdy0", req0_ready, 1);
    chk("sim3_addr", dm_addr, 12'h022);
    tick();
    req0_valid = 1'b0;
    chk("sim3_rsp0_valid", rsp0_valid, 1);
    chk("sim3_rsp0_rdata", rsp0_rdata, pat(12'h022));

    // write then read-after-write on requester 0
    set0(1'b1, 1'b1, 1'b0, 12'h010, 32'hDEAD_BEEF);
    #1;
    chk("wr_rdy0", req0_ready, 1);
    chk("wr_dm_we", dm_we, 1);
    chk("wr_dm_addr", dm_addr, 12'h010);
    chk("wr_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
    tick();
    set0(1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    #1;
    chk("wr_no_rsp", rsp0_valid, 0);
    chk("raw_rdy0", req0_ready, 1);
    chk("raw_dm_we", dm_we, 0);
    tick();
    req0_valid = 1'b0;
    chk("raw_rsp0_valid", rsp0_valid, 1);
    chk("raw_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
    chk("raw_rsp1_valid", rsp1_valid, 0);
    tick();
    chk("hold_rsp0_valid", rsp0_valid, 0);
    chk("hold_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);

    // single loader write moves the pointer back to 0
    set1(1'b1, 1'b1, 1'b0, 12'h200, 32'h1234_5678);
    #1;
    chk("ldw_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("ldw_no_rsp", rsp1_valid, 0);
    chk("ldw_ptr", dbg_ptr, 0);

    // both read every cycle: grants alternate 0,1,0,1...
    a0 = 12'h040;
    a1 = 12'h080;
    for (int i = 0; i < 8; i++) begin
      set0(1'b1, 1'b0, 1'b0, a0, 32'h0);
      set1(1'b1, 1'b0, 1'b0, a1, 32'h0);
      #1;
      w  = (i % 2) == 1;
      ga = w ? a1 : a0;
      chk("alt_rdy0", req0_ready, !w);
      chk("alt_rdy1", req1_ready, w);
      chk("alt_addr", dm_addr, ga);
      tick();
      chk("alt_rsp0_valid", rsp0_valid, !w);
      chk("alt_rsp1_valid", rsp1_valid, w);
      chk("alt_rdata", w ? rsp1_rdata : rsp0_rdata, pat(ga));
      if (w) a1 = a1 + 12'd1;
      else   a0 = a0 + 12'd1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // locked 4-beat loader burst with the CPU waiting
    for (int i = 0; i < 4; i++) begin
      set1(1'b1, 1'b1, (i < 3), 12'h100 + 12'(i), 32'hB000_0000 + 32'(i));
      if (i >= 1) set0(1'b1, 1'b0, 1'b0, 12'h030, 32'h0);
      #1;
      chk("lk_rdy1", req1_ready, 1);
      chk("lk_rdy0", req0_ready, 0);
      chk("lk_dm_we", dm_we, 1);
      chk("lk_dm_addr", dm_addr, 12'h100 + 12'(i));
      tick();
      chk("lk_state", dbg_state, (i < 3) ? OWN1 : IDLE);
    end
    set1(1'b1, 1'b1, 1'b0, 12'h104, 32'hB000_0004);
    #1;
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_rdy1", req1_ready, 0);
    chk("rel_addr", dm_addr, 12'h030);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("rel_rsp0_valid", rsp0_valid, 1);
    chk("rel_rsp0_rdata", rsp0_rdata, pat(12'h030));
    chk("rel2_rdy1", req1_ready, 1);
    chk("rel2_addr", dm_addr, 12'h104);
    tick();
    req1_valid = 1'b0;

    // CPU lock blocks the loader even while the CPU is idle
    set0(1'b1, 1'b1, 1'b1, 12'h011, 32'h0000_1111);
    #1;
    chk("own0_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    set1(1'b1, 1'b0, 1'b0, 12'h101, 32'h0);
    #1;
    chk("own0_state", dbg_state, OWN0);
    chk("own0_rdy1a", req1_ready, 0);
    tick();
    chk("own0_rdy1b", req1_ready, 0);
    set0(1'b1, 1'b1, 1'b0, 12'h012, 32'h0000_2222);
    #1;
    chk("own0_unlock_rdy0", req0_ready, 1);
    chk("own0_unlock_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("own0_after_rdy1", req1_ready, 1);
    chk("own0_after_addr", dm_addr, 12'h101);
    tick();
    req1_valid = 1'b0;
    chk("burst_rb_valid", rsp1_valid, 1);
    chk("burst_rb_rdata", rsp1_rdata, 32'hB000_0001);

    // reset while a read is pending drops the response
    set0(1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    #1;
    chk("rr_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_rsp0_valid", rsp0_valid, 0);
    chk("rr_rsp1_valid", rsp1_valid, 0);
    tick();
    chk("rr_state", dbg_state, IDLE);
    chk("rr_ptr", dbg_ptr, 0);
    chk("rr_rsp0_rdata", rsp0_rdata, 0);
    chk("rr_rsp1_rdata", rsp1_rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("rr_post_rsp0_valid", rsp0_valid, 0);
    chk("rr_post_rsp1_valid", rsp1_valid, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
